// File: rtl/icache_tag_ctrl.sv
// Tag SRAM sequencer for one icache bank: clears the bank after reset and on flush,
// arbitrates refill writes against lookup reads, and returns hit/miss the cycle after a grant.
module icache_tag_ctrl #(
    parameter int NumWords  = 8,
    parameter int DataWidth = 9
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_req_i,
    output logic                     flush_ack_o,
    output logic                     busy_o,
    input  logic                     lookup_req_i,
    output logic                     lookup_gnt_o,
    input  logic [$clog2(NumWords)-1:0] lookup_addr_i,
    input  logic [DataWidth-2:0]     lookup_tag_i,
    output logic                     lookup_rvalid_o,
    output logic                     lookup_hit_o,
    output logic [DataWidth-2:0]     lookup_rtag_o,
    input  logic                     refill_req_i,
    output logic                     refill_gnt_o,
    input  logic [$clog2(NumWords)-1:0] refill_addr_i,
    input  logic [DataWidth-2:0]     refill_tag_i,
    output logic                     sram_req_o,
    output logic                     sram_we_o,
    output logic [$clog2(NumWords)-1:0] sram_addr_o,
    output logic [DataWidth-1:0]     sram_wdata_o,
    output logic [(DataWidth+7)/8-1:0] sram_be_o,
    input  logic [DataWidth-1:0]     sram_rdata_i
);
    localparam int AW = $clog2(NumWords);
    localparam int BW = (DataWidth + 7) / 8;
    localparam int TW = DataWidth - 1;
    localparam logic [AW-1:0] LAST = AW'(NumWords - 1);

    typedef enum logic [1:0] {INIT, IDLE, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          ack_q, ack_d;
    logic          rvalid_q;
    logic [TW-1:0] tag_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        ack_d        = 1'b0;
        busy_o       = 1'b0;
        refill_gnt_o = 1'b0;
        lookup_gnt_o = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        case (state_q)
            INIT, FLUSH: begin
                busy_o      = 1'b1;
                sram_req_o  = 1'b1;
                sram_we_o   = 1'b1;
                sram_addr_o = cnt_q;
                cnt_d       = cnt_q + 1'b1;
                // A flush requested during INIT is satisfied by the INIT sweep itself.
                if (state_q == INIT && flush_req_i) pend_d = 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    pend_d  = 1'b0;
                    ack_d   = (state_q == FLUSH) || pend_q || flush_req_i;
                end
            end
            IDLE: begin
                if (flush_req_i && !ack_q) begin
                    state_d = FLUSH;
                end else if (refill_req_i) begin
                    refill_gnt_o = 1'b1;
                    sram_req_o   = 1'b1;
                    sram_we_o    = 1'b1;
                    sram_addr_o  = refill_addr_i;
                    sram_wdata_o = {1'b1, refill_tag_i};
                end else if (lookup_req_i) begin
                    lookup_gnt_o = 1'b1;
                    sram_req_o   = 1'b1;
                    sram_addr_o  = lookup_addr_i;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= INIT;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            ack_q    <= 1'b0;
            rvalid_q <= 1'b0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            ack_q    <= ack_d;
            rvalid_q <= lookup_gnt_o;
            if (lookup_gnt_o) tag_q <= lookup_tag_i;
        end
    end

    assign flush_ack_o     = ack_q;
    assign lookup_rvalid_o = rvalid_q;
    assign lookup_rtag_o   = sram_rdata_i[TW-1:0];
    assign lookup_hit_o    = rvalid_q && sram_rdata_i[TW] && (sram_rdata_i[TW-1:0] == tag_q);
    assign sram_be_o       = {BW{1'b1}};

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Bench for icache_tag_ctrl: behavioural tag SRAM, directed sequences, a vector table
// and a randomized phase against an array-based tag store model.
module tb_icache_tag_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       flush_ack, busy;
    logic       lookup = 1'b0;
    logic       lookup_gnt;
    logic [2:0] laddr = '0;
    logic [7:0] ltag = '0;
    logic       rvalid, hit;
    logic [7:0] rtag_out;
    logic       refill = 1'b0;
    logic       refill_gnt;
    logic [2:0] raddr = '0;
    logic [7:0] rtag = '0;
    logic       sram_req, sram_we;
    logic [2:0] sram_addr;
    logic [8:0] sram_wdata;
    logic [1:0] sram_be;
    logic [8:0] sram_rdata = '0;

    logic [8:0] mem [8] = '{9'h1A5, 9'h15A, 9'h1FF, 9'h15A, 9'h133, 9'h112, 9'h101, 9'h0C3};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= mem[sram_addr];
        end
    end

    icache_tag_ctrl #(.NumWords(8), .DataWidth(9)) dut (
        .clk_i(clk), .rst_i(rst),
        .flush_req_i(flush), .flush_ack_o(flush_ack), .busy_o(busy),
        .lookup_req_i(lookup), .lookup_gnt_o(lookup_gnt),
        .lookup_addr_i(laddr), .lookup_tag_i(ltag),
        .lookup_rvalid_o(rvalid), .lookup_hit_o(hit), .lookup_rtag_o(rtag_out),
        .refill_req_i(refill), .refill_gnt_o(refill_gnt),
        .refill_addr_i(raddr), .refill_tag_i(rtag),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Entered just after the edge that starts a sweep; leaves just after the edge that ends it.
    task automatic sweep_chk(input string name);
        refill = 1'b1;
        lookup = 1'b1;
        raddr  = 3'd6;
        laddr  = 3'd6;
        for (int i = 0; i < 8; i++) begin
            mid();
            chk({name, " busy"}, busy, 1);
            chk({name, " req"}, sram_req, 1);
            chk({name, " we"}, sram_we, 1);
            chk({name, " addr"}, sram_addr, i);
            chk({name, " wdata"}, sram_wdata, 0);
            chk({name, " be"}, sram_be, 2'b11);
            chk({name, " grants"}, {refill_gnt, lookup_gnt}, 0);
            chk({name, " ack"}, flush_ack, 0);
            chk({name, " rvalid"}, rvalid, 0);
            nxt();
        end
        refill = 1'b0;
        lookup = 1'b0;
    endtask

    typedef struct {
        logic       ref_req;
        logic       lk_req;
        logic [2:0] ra;
        logic [7:0] rt;
        logic [2:0] la;
        logic [7:0] lt;
        logic       exp_rg;
        logic       exp_lg;
        logic       exp_rv;
        logic       exp_hit;
        logic [7:0] exp_rtag;
    } vec_t;

    vec_t vecs [9];

    logic       mv [8];
    logic [7:0] mt [8];
    logic       pend, ehit;
    logic [7:0] ertag;
    logic [7:0] tag_pool [4];

    initial begin
        vecs[0] = '{0, 1, 3'd0, 8'h00, 3'd3, 8'h5A, 0, 1, 0, 0, 8'h00};
        vecs[1] = '{1, 0, 3'd3, 8'h44, 3'd0, 8'h00, 1, 0, 1, 1, 8'h5A};
        vecs[2] = '{0, 1, 3'd0, 8'h00, 3'd3, 8'h44, 0, 1, 0, 0, 8'h00};
        vecs[3] = '{0, 1, 3'd0, 8'h00, 3'd3, 8'h5A, 0, 1, 1, 1, 8'h44};
        vecs[4] = '{1, 1, 3'd5, 8'h12, 3'd5, 8'h12, 1, 0, 1, 0, 8'h44};
        vecs[5] = '{0, 1, 3'd0, 8'h00, 3'd5, 8'h12, 0, 1, 0, 0, 8'h00};
        vecs[6] = '{0, 0, 3'd0, 8'h00, 3'd0, 8'h00, 0, 0, 1, 1, 8'h12};
        vecs[7] = '{0, 1, 3'd0, 8'h00, 3'd0, 8'h00, 0, 1, 0, 0, 8'h00};
        vecs[8] = '{0, 0, 3'd0, 8'h00, 3'd0, 8'h00, 0, 0, 1, 0, 8'h00};
        tag_pool = '{8'h5A, 8'h5B, 8'h11, 8'h00};

        // Reset state and INIT sweep
        nxt();
        mid();
        chk("reset rvalid", rvalid, 0);
        chk("reset ack", flush_ack, 0);
        chk("reset busy", busy, 1);
        nxt();
        rst = 1'b0;
        sweep_chk("init");
        lookup = 1'b1; laddr = 3'd3; ltag = 8'h5A;
        mid();
        chk("post-init busy", busy, 0);
        chk("post-init ack", flush_ack, 0);
        chk("lk1 gnt", lookup_gnt, 1);
        chk("lk1 sram rd", {sram_req, sram_we, sram_addr}, {1'b1, 1'b0, 3'd3});
        nxt();
        lookup = 1'b0;
        mid();
        chk("lk1 rvalid", rvalid, 1);
        chk("lk1 hit", hit, 0);
        chk("lk1 rtag", rtag_out, 0);
        nxt();

        // Refill then lookups
        refill = 1'b1; raddr = 3'd3; rtag = 8'h5A;
        mid();
        chk("rf gnt", refill_gnt, 1);
        chk("rf write", {sram_req, sram_we, sram_addr, sram_wdata}, {1'b1, 1'b1, 3'd3, 9'h15A});
        nxt();
        refill = 1'b0; lookup = 1'b1; laddr = 3'd3; ltag = 8'h5A;
        mid();
        chk("lk2 gnt", lookup_gnt, 1);
        chk("lk2 idle rvalid", rvalid, 0);
        nxt();
        ltag = 8'h5B;
        mid();
        chk("lk2 rvalid", rvalid, 1);
        chk("lk2 hit", hit, 1);
        chk("lk2 rtag", rtag_out, 8'h5A);
        chk("lk3 gnt", lookup_gnt, 1);
        nxt();
        lookup = 1'b0;
        mid();
        chk("lk3 rvalid", rvalid, 1);
        chk("lk3 hit", hit, 0);
        chk("lk3 rtag", rtag_out, 8'h5A);
        nxt();
        mid();
        chk("idle rvalid", rvalid, 0);
        chk("idle hit", hit, 0);
        nxt();

        // Simultaneous refill and lookup
        refill = 1'b1; raddr = 3'd2; rtag = 8'h33;
        lookup = 1'b1; laddr = 3'd2; ltag = 8'h33;
        mid();
        chk("both rgnt", refill_gnt, 1);
        chk("both lgnt", lookup_gnt, 0);
        nxt();
        refill = 1'b0;
        mid();
        chk("retry lgnt", lookup_gnt, 1);
        nxt();
        lookup = 1'b0;
        mid();
        chk("retry rvalid", rvalid, 1);
        chk("retry hit", hit, 1);
        nxt();

        // Back-to-back vector table
        for (int i = 0; i < 9; i++) begin
            refill = vecs[i].ref_req; raddr = vecs[i].ra; rtag = vecs[i].rt;
            lookup = vecs[i].lk_req;  laddr = vecs[i].la; ltag = vecs[i].lt;
            mid();
            chk($sformatf("vec%0d rgnt", i), refill_gnt, vecs[i].exp_rg);
            chk($sformatf("vec%0d lgnt", i), lookup_gnt, vecs[i].exp_lg);
            chk($sformatf("vec%0d rvalid", i), rvalid, vecs[i].exp_rv);
            chk($sformatf("vec%0d hit", i), hit, vecs[i].exp_hit);
            if (vecs[i].exp_rv) chk($sformatf("vec%0d rtag", i), rtag_out, vecs[i].exp_rtag);
            nxt();
        end
        refill = 1'b0; lookup = 1'b0;

        // Flush sweep
        refill = 1'b1; raddr = 3'd3; rtag = 8'h5A;
        mid();
        chk("pre-flush rgnt", refill_gnt, 1);
        nxt();
        flush = 1'b1;
        mid();
        chk("flush entry grants", {refill_gnt, lookup_gnt}, 0);
        chk("flush entry sram", sram_req, 0);
        nxt();
        refill = 1'b0;
        sweep_chk("flush");
        mid();
        chk("flush ack", flush_ack, 1);
        chk("flush ack busy", busy, 0);
        chk("flush ack sram", sram_req, 0);
        nxt();
        flush = 1'b0;
        lookup = 1'b1; laddr = 3'd3; ltag = 8'h5A;
        mid();
        chk("flush ack drop", flush_ack, 0);
        chk("post-flush lgnt", lookup_gnt, 1);
        nxt();
        lookup = 1'b0;
        mid();
        chk("post-flush rvalid", rvalid, 1);
        chk("post-flush hit", hit, 0);
        nxt();

        // Reset in the middle of a flush sweep
        flush = 1'b1;
        nxt();
        repeat (4) nxt();
        mid();
        chk("mid-sweep addr", sram_addr, 4);
        chk("mid-sweep busy", busy, 1);
        rst = 1'b1; flush = 1'b0;
        nxt();
        rst = 1'b0;
        sweep_chk("rst-sweep");
        mid();
        chk("rst-sweep ack", flush_ack, 0);
        chk("rst-sweep done", busy, 0);
        nxt();

        // Reset landing on a lookup's result edge
        lookup = 1'b1; laddr = 3'd1; ltag = 8'h00;
        mid();
        chk("rst-lk gnt", lookup_gnt, 1);
        rst = 1'b1; lookup = 1'b0;
        nxt();
        rst = 1'b0;
        sweep_chk("rst-lk");
        mid();
        chk("rst-lk done", busy, 0);
        nxt();

        // Flush request during INIT
        rst = 1'b1;
        nxt();
        rst = 1'b0; flush = 1'b1;
        sweep_chk("init-flush");
        mid();
        chk("init-flush ack", flush_ack, 1);
        chk("init-flush busy", busy, 0);
        chk("init-flush sram", sram_req, 0);
        nxt();
        flush = 1'b0;
        mid();
        chk("init-flush ack drop", flush_ack, 0);
        chk("init-flush no resweep", {busy, sram_req}, 0);
        nxt();
        mid();
        chk("init-flush still idle", {busy, sram_req, flush_ack}, 0);
        nxt();

        // Randomized refill/lookup traffic against the tag store model
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            mt[i] = 8'h00;
        end
        pend = 1'b0; ehit = 1'b0; ertag = 8'h00;
        for (int n = 0; n < 300; n++) begin
            refill = ($urandom_range(0, 2) == 0);
            lookup = ($urandom_range(0, 1) == 1);
            raddr  = 3'($urandom_range(0, 7));
            laddr  = 3'($urandom_range(0, 7));
            rtag   = tag_pool[$urandom_range(0, 3)];
            ltag   = tag_pool[$urandom_range(0, 3)];
            mid();
            chk("rnd rgnt", refill_gnt, refill);
            chk("rnd lgnt", lookup_gnt, lookup && !refill);
            chk("rnd rvalid", rvalid, pend);
            chk("rnd hit", hit, pend && ehit);
            if (pend) chk("rnd rtag", rtag_out, ertag);
            if (refill) chk("rnd wr", {sram_we, sram_addr, sram_wdata}, {1'b1, raddr, 1'b1, rtag});
            if (lookup && !refill) begin
                pend  = 1'b1;
                ehit  = mv[laddr] && (mt[laddr] == ltag);
                ertag = mt[laddr];
            end else begin
                pend = 1'b0;
            end
            if (refill) begin
                mv[raddr] = 1'b1;
                mt[raddr] = rtag;
            end
            nxt();
        end
        refill = 1'b0; lookup = 1'b0;
        mid();
        chk("rnd last rvalid", rvalid, pend);
        chk("rnd last hit", hit, pend && ehit);
        if (pend) chk("rnd last rtag", rtag_out, ertag);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
